// File: rtl/oled_iic_pkg.sv
// Shared definitions for the OLED-side IIC target: FSM encodings, control-byte
// bit positions and the default 7-bit bus address.
package oled_iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CTRL     = 3'd3,
    ST_CTRL_ACK = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam int          CTRL_CO_BIT        = 7;
  localparam int          CTRL_DC_BIT        = 6;
  localparam logic [6:0]  DEFAULT_SLAVE_ADDR = 7'h3C;

endpackage

// File: rtl/oled_iic_slave_rx_if.sv
// Receive-side signal bundle of the OLED IIC target: SCL in, decoded strobes out.
// SDA is open-drain and stays a plain inout on the top so tristate resolution is simple.
interface oled_iic_slave_rx_if;
  logic       iic_scl;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_is_data;
  logic       frame_start;
  logic       frame_end;
  logic       frame_active;
  logic       err_read;

  modport slave (
    input  iic_scl,
    output rx_valid, rx_byte, rx_is_data, frame_start, frame_end, frame_active, err_read
  );

  modport master (
    output iic_scl,
    input  rx_valid, rx_byte, rx_is_data, frame_start, frame_end, frame_active, err_read
  );
endinterface

// File: rtl/oled_iic_cond_det.sv
// SCL/SDA synchronizers plus SCL edge and START/STOP detection.
// SYNC_STAGES must be at least 2; flops preset to the idle-high bus level.
module oled_iic_cond_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  // START/STOP qualify on the previous SCL level so a coincident SCL fall still counts.
  assign start_det =  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/oled_iic_slave_rx.sv
// IIC write-only target modelling the SSD1306 end of the bus: address match,
// control byte (Co, D/C#) decode, payload strobes and frame framing pulses.
module oled_iic_slave_rx
  import oled_iic_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk_50m,
  input  logic                      rst,
  inout  wire                       iic_sda,
  oled_iic_slave_rx_if.slave        bus
);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt, byte_full;
  logic       co, co_nxt, dc, dc_nxt;
  logic       sda_low, sda_low_nxt, ack_drv, ack_drv_nxt;
  logic [7:0] rx_byte, rx_byte_nxt;
  logic       rx_is_data, rx_is_data_nxt, rx_valid, rx_valid_nxt;
  logic       frame_start, frame_start_nxt, frame_end, frame_end_nxt;
  logic       frame_active, frame_active_nxt, err_read, err_read_nxt;

  oled_iic_cond_det #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk       (clk_50m),
    .rst       (rst),
    .scl_in    (bus.iic_scl),
    .sda_in    (iic_sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign iic_sda = sda_low ? 1'b0 : 1'bz;
  assign byte_full = {shift[6:0], sda_s};

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      co           <= 1'b0;
      dc           <= 1'b0;
      sda_low      <= 1'b0;
      ack_drv      <= 1'b0;
      rx_byte      <= 8'h00;
      rx_is_data   <= 1'b0;
      rx_valid     <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_active <= 1'b0;
      err_read     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      co           <= co_nxt;
      dc           <= dc_nxt;
      sda_low      <= sda_low_nxt;
      ack_drv      <= ack_drv_nxt;
      rx_byte      <= rx_byte_nxt;
      rx_is_data   <= rx_is_data_nxt;
      rx_valid     <= rx_valid_nxt;
      frame_start  <= frame_start_nxt;
      frame_end    <= frame_end_nxt;
      frame_active <= frame_active_nxt;
      err_read     <= err_read_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    bit_cnt_nxt      = bit_cnt;
    shift_nxt        = shift;
    co_nxt           = co;
    dc_nxt           = dc;
    sda_low_nxt      = sda_low;
    ack_drv_nxt      = ack_drv;
    rx_byte_nxt      = rx_byte;
    rx_is_data_nxt   = rx_is_data;
    rx_valid_nxt     = 1'b0;
    frame_start_nxt  = 1'b0;
    frame_end_nxt    = 1'b0;
    frame_active_nxt = frame_active;
    err_read_nxt     = err_read;

    case (state)
      ST_ADDR, ST_CTRL, ST_DATA: begin
        if (scl_rise) begin
          shift_nxt   = byte_full;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (state == ST_ADDR) begin
              if (byte_full[7:1] != SLAVE_ADDR) begin
                state_nxt = ST_IGNORE;
              end else if (byte_full[0]) begin
                err_read_nxt = 1'b1;
                state_nxt    = ST_IGNORE;
              end else begin
                frame_start_nxt = 1'b1;
                state_nxt       = ST_ADDR_ACK;
              end
            end else if (state == ST_CTRL) begin
              co_nxt    = byte_full[CTRL_CO_BIT];
              dc_nxt    = byte_full[CTRL_DC_BIT];
              state_nxt = ST_CTRL_ACK;
            end else begin
              rx_byte_nxt    = byte_full;
              rx_is_data_nxt = dc;
              rx_valid_nxt   = 1'b1;
              state_nxt      = ST_DATA_ACK;
            end
          end
        end
      end
      ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
        // First SCL fall after the 8th bit grabs SDA; the 9th fall lets it go.
        if (scl_fall) begin
          if (!ack_drv) begin
            sda_low_nxt = 1'b1;
            ack_drv_nxt = 1'b1;
          end else begin
            sda_low_nxt = 1'b0;
            ack_drv_nxt = 1'b0;
            bit_cnt_nxt = 4'd0;
            if (state == ST_ADDR_ACK) begin
              state_nxt        = ST_CTRL;
              frame_active_nxt = 1'b1;
            end else if (state == ST_CTRL_ACK) begin
              state_nxt = ST_DATA;
            end else begin
              state_nxt = co ? ST_CTRL : ST_DATA;
            end
          end
        end
      end
      default: ;
    endcase

    // Bus conditions override whatever the bit-level logic decided this cycle.
    if (start_det || stop_det) begin
      rx_valid_nxt    = 1'b0;
      frame_start_nxt = 1'b0;
      sda_low_nxt     = 1'b0;
      ack_drv_nxt     = 1'b0;
      bit_cnt_nxt     = 4'd0;
      if (frame_active) begin
        frame_end_nxt    = 1'b1;
        frame_active_nxt = 1'b0;
      end
      state_nxt = start_det ? ST_ADDR : ST_IDLE;
    end
  end

  assign bus.rx_valid     = rx_valid;
  assign bus.rx_byte      = rx_byte;
  assign bus.rx_is_data   = rx_is_data;
  assign bus.frame_start  = frame_start;
  assign bus.frame_end    = frame_end;
  assign bus.frame_active = frame_active;
  assign bus.err_read     = err_read;

endmodule

// File: tb/tb_oled_iic_slave_rx.sv
// Directed bench for oled_iic_slave_rx: bit-banged IIC master, strobe monitor,
// and per-scenario tasks with hand-computed expectations.
module tb_oled_iic_slave_rx;
  import oled_iic_pkg::*;

  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_low = 1'b0;
  wire  iic_sda;

  oled_iic_slave_rx_if bus ();

  assign iic_sda = m_low ? 1'b0 : 1'bz;
  pullup (iic_sda);

  oled_iic_slave_rx #(.SLAVE_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk_50m (clk),
    .rst     (rst),
    .iic_sda (iic_sda),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  int slave_low_cnt = 0;
  int rel_err = 0;
  logic [8:0] rxq[$];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rxq.push_back({bus.rx_is_data, bus.rx_byte});
    if (bus.frame_start === 1'b1) fs_cnt++;
    if (bus.frame_end === 1'b1) fe_cnt++;
    if (!m_low && iic_sda === 1'b0) slave_low_cnt++;
  end

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    m_low = 1'b0; wait_q();
    bus.iic_scl = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    bus.iic_scl = 1'b0; wait_q();
  endtask

  task automatic do_stop();
    m_low = 1'b1; wait_q();
    bus.iic_scl = 1'b1; wait_q();
    m_low = 1'b0; wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wait_q();
    bus.iic_scl = 1'b1; wait_q(2);
    bus.iic_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; wait_q();
    bus.iic_scl = 1'b1; wait_q();
    acked = (iic_sda === 1'b0);
    wait_q();
    bus.iic_scl = 1'b0; wait_q();
    if (iic_sda !== 1'b1) rel_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.iic_scl = 1'b1; m_low = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
    checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", bus.rx_byte); end
    checks++; if (bus.rx_is_data !== 1'b0) begin errors++; $display("FAIL reset_rx_is_data got %b want 0", bus.rx_is_data); end
    checks++; if (bus.frame_start !== 1'b0 || bus.frame_end !== 1'b0 || bus.frame_active !== 1'b0) begin
      errors++; $display("FAIL reset_frame got %b%b%b want 000", bus.frame_start, bus.frame_end, bus.frame_active); end
    checks++; if (bus.err_read !== 1'b0) begin errors++; $display("FAIL reset_err_read got %b want 0", bus.err_read); end
    checks++; if (iic_sda !== 1'b1) begin errors++; $display("FAIL reset_sda_released got %b want 1", iic_sda); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checks++; if (fs_cnt !== 0) begin errors++; $display("FAIL reset_no_frame_start got %0d want 0", fs_cnt); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_cmd_stream();
    int fs0 = fs_cnt, fe0 = fe_cnt, q0 = rxq.size(), r0 = rel_err;
    logic a0, a1, a2, a3;
    do_start();
    send_byte(8'h78, a0); send_byte(8'h00, a1); send_byte(8'hAE, a2); send_byte(8'hD5, a3);
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL cmd_acks got %b want 1111", {a0, a1, a2, a3}); end
    checks++; if (bus.frame_active !== 1'b1) begin errors++; $display("FAIL cmd_frame_active got %b want 1", bus.frame_active); end
    do_stop();
    checks++; if (rxq.size() - q0 !== 2) begin errors++; $display("FAIL cmd_strobe_count got %0d want 2", rxq.size() - q0); end
    else begin
      checks++; if (rxq[q0] !== 9'h0AE) begin errors++; $display("FAIL cmd_byte0 got %h want 0AE", rxq[q0]); end
      checks++; if (rxq[q0+1] !== 9'h0D5) begin errors++; $display("FAIL cmd_byte1 got %h want 0D5", rxq[q0+1]); end
    end
    checks++; if (fs_cnt - fs0 !== 1 || fe_cnt - fe0 !== 1) begin
      errors++; $display("FAIL cmd_frame_pulses got start=%0d end=%0d want 1/1", fs_cnt - fs0, fe_cnt - fe0); end
    checks++; if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL cmd_frame_closed got %b want 0", bus.frame_active); end
    checks++; if (bus.rx_byte !== 8'hD5) begin errors++; $display("FAIL cmd_rx_byte_hold got %h want D5", bus.rx_byte); end
    checks++; if (rel_err - r0 !== 0) begin errors++; $display("FAIL cmd_ack_release got %0d late releases want 0", rel_err - r0); end
  endtask

  task automatic test_data_stream();
    int q0 = rxq.size();
    logic a0, a1, a2, a3, a4;
    do_start();
    send_byte(8'h78, a0); send_byte(8'h40, a1); send_byte(8'h7E, a2); send_byte(8'h11, a3);
    do_stop();
    checks++; if (rxq.size() - q0 !== 2) begin errors++; $display("FAIL data_strobe_count got %0d want 2", rxq.size() - q0); end
    else begin
      checks++; if (rxq[q0] !== 9'h17E) begin errors++; $display("FAIL data_byte0 got %h want 17E", rxq[q0]); end
      checks++; if (rxq[q0+1] !== 9'h111) begin errors++; $display("FAIL data_byte1 got %h want 111", rxq[q0+1]); end
    end
    q0 = rxq.size();
    do_start();
    send_byte(8'h78, a0); send_byte(8'h80, a1); send_byte(8'hB0, a2); send_byte(8'hC0, a3); send_byte(8'hFF, a4);
    do_stop();
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin errors++; $display("FAIL co_acks got %b want 11111", {a0, a1, a2, a3, a4}); end
    checks++; if (rxq.size() - q0 !== 2) begin errors++; $display("FAIL co_strobe_count got %0d want 2", rxq.size() - q0); end
    else begin
      checks++; if (rxq[q0] !== 9'h0B0) begin errors++; $display("FAIL co_cmd_byte got %h want 0B0", rxq[q0]); end
      checks++; if (rxq[q0+1] !== 9'h1FF) begin errors++; $display("FAIL co_data_byte got %h want 1FF", rxq[q0+1]); end
    end
  endtask

  task automatic test_wrong_addr_read();
    int q0 = rxq.size(), fs0 = fs_cnt, sl0 = slave_low_cnt;
    logic a0, a1;
    do_start();
    send_byte(8'h7A, a0); send_byte(8'h00, a1);
    do_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL wrong_addr_nack got %b want 00", {a0, a1}); end
    checks++; if (slave_low_cnt - sl0 !== 0 || rxq.size() - q0 !== 0 || fs_cnt - fs0 !== 0) begin
      errors++; $display("FAIL wrong_addr_silent got low=%0d strobes=%0d starts=%0d want 0/0/0",
                         slave_low_cnt - sl0, rxq.size() - q0, fs_cnt - fs0); end
    checks++; if (bus.err_read !== 1'b0) begin errors++; $display("FAIL wrong_addr_err_read got %b want 0", bus.err_read); end
    sl0 = slave_low_cnt;
    do_start();
    send_byte(8'h79, a0);
    do_stop();
    checks++; if (a0 !== 1'b0 || slave_low_cnt - sl0 !== 0) begin
      errors++; $display("FAIL read_nack got ack=%b low=%0d want 0/0", a0, slave_low_cnt - sl0); end
    checks++; if (bus.err_read !== 1'b1) begin errors++; $display("FAIL read_err_read got %b want 1", bus.err_read); end
    checks++; if (fs_cnt - fs0 !== 0) begin errors++; $display("FAIL read_no_frame got %0d want 0", fs_cnt - fs0); end
  endtask

  task automatic test_abort();
    int q0 = rxq.size(), fe0 = fe_cnt;
    logic a0, a1, a2;
    do_start();
    send_byte(8'h78, a0); send_byte(8'h00, a1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    do_stop();
    checks++; if (rxq.size() - q0 !== 0) begin errors++; $display("FAIL abort_no_strobe got %0d want 0", rxq.size() - q0); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL abort_frame_end got %0d want 1", fe_cnt - fe0); end
    do_start();
    send_byte(8'h78, a0); send_byte(8'h00, a1); send_byte(8'hAF, a2);
    do_stop();
    checks++; if (rxq.size() - q0 !== 1) begin errors++; $display("FAIL abort_next_count got %0d want 1", rxq.size() - q0); end
    else begin
      checks++; if (rxq[q0] !== 9'h0AF) begin errors++; $display("FAIL abort_next_byte got %h want 0AF", rxq[q0]); end
    end
    checks++; if (bus.err_read !== 1'b1) begin errors++; $display("FAIL err_read_sticky got %b want 1", bus.err_read); end
  endtask

  task automatic test_async_reset();
    int fe0, fs0;
    logic a0;
    do_start();
    send_byte(8'h78, a0);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    m_low = 1'b0; wait_q();
    checks++; if (iic_sda !== 1'b0 || bus.frame_active !== 1'b1) begin
      errors++; $display("FAIL areset_pre got sda=%b active=%b want 0/1", iic_sda, bus.frame_active); end
    fe0 = fe_cnt; fs0 = fs_cnt;
    rst = 1'b1;
    #1;
    checks++; if (iic_sda !== 1'b1) begin errors++; $display("FAIL areset_sda_release got %b want 1", iic_sda); end
    checks++; if (bus.frame_active !== 1'b0 || dut.state !== ST_IDLE) begin
      errors++; $display("FAIL areset_state got active=%b state=%0d want 0/%0d", bus.frame_active, dut.state, ST_IDLE); end
    bus.iic_scl = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    wait_q(4);
    checks++; if (fe_cnt - fe0 !== 0 || fs_cnt - fs0 !== 0) begin
      errors++; $display("FAIL areset_no_pulses got end=%0d start=%0d want 0/0", fe_cnt - fe0, fs_cnt - fs0); end
    checks++; if (bus.err_read !== 1'b0) begin errors++; $display("FAIL areset_err_read_clear got %b want 0", bus.err_read); end
  endtask

  initial begin
    bus.iic_scl = 1'b1;
    test_reset();
    test_cmd_stream();
    test_data_stream();
    test_wrong_addr_read();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
